// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: N-stage stall/bubble/flush controller with a sticky stall watchdog.
// Defining PIPE_HAZARD_PERF_EN adds saturating stall/redirect performance counters.
module pipe_hazard_ctrl #(
    parameter int STAGES    = 5,
    parameter int FLUSH_LEN = 1,
    parameter int WDOG_W    = 10,
    parameter int PERF_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [STAGES-1:0]         stall_req,
    input  logic                      redirect,
    input  logic [$clog2(STAGES)-1:0] redirect_stage,
    output logic [STAGES-1:0]         stall,
    output logic [STAGES-1:0]         bubble,
    output logic [STAGES-1:0]         flush,
    output logic                      wdog_trip,
    output logic [PERF_W-1:0]         perf_stall_cnt,
    output logic [PERF_W-1:0]         perf_flush_cnt
);
    localparam int RW = $clog2(STAGES);
    localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_LEN - 1);
    localparam logic [WDOG_W-1:0] WONE = {{(WDOG_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WDOG  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [RW-1:0]       r_q, r_d;
    logic [3:0]          fcnt_q, fcnt_d;
    logic [WDOG_W-1:0]   wcnt_q, wcnt_d;
    logic [STAGES-1:0]   flush_q, flush_d;
    logic                trip_q, trip_d;
    logic [STAGES-1:0]   base_s, stall_s, bubble_s;
    logic                seen_s, accept_s, wsat_s;

    // Stall vector: everything at or below the highest requester, with flushed stages released.
    always_comb begin
        base_s = {STAGES{1'b0}};
        seen_s = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            seen_s    = seen_s | stall_req[i];
            base_s[i] = seen_s;
        end
        if (rst || !rdy || (state_q == ST_WDOG)) begin
            stall_s = {STAGES{1'b1}};
        end else begin
            stall_s = base_s & ~flush_q;
        end
    end

    // Bubble at the boundary between a held stage and a moving, non-flushed successor.
    always_comb begin
        bubble_s = {STAGES{1'b0}};
        for (int i = 0; i < STAGES - 1; i++) begin
            bubble_s[i+1] = stall_s[i] & ~stall_s[i+1] & ~flush_q[i+1];
        end
    end

    // Watchdog counter next state and flush/watchdog FSM transitions.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        fcnt_d  = fcnt_q;
        trip_d  = trip_q;
        if (|stall_req) begin
            wcnt_d = (&wcnt_q) ? wcnt_q : (wcnt_q + WONE);
        end else begin
            wcnt_d = {WDOG_W{1'b0}};
        end
        wsat_s   = &wcnt_d;
        accept_s = redirect & rdy & (redirect_stage != {RW{1'b0}}) &
                   (state_q != ST_WDOG) & ~wsat_s;
        if (wsat_s) begin
            state_d = ST_WDOG;
            trip_d  = 1'b1;
            fcnt_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d = ST_FLUSH;
                        r_d     = redirect_stage;
                        fcnt_d  = FCNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    // A restart keeps the deeper flush so no older stage escapes.
                    if (accept_s) begin
                        r_d    = (redirect_stage > r_q) ? redirect_stage : r_q;
                        fcnt_d = FCNT_LOAD;
                    end else if (rdy) begin
                        if (fcnt_q == 4'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            fcnt_d = fcnt_q - 4'd1;
                        end
                    end else begin
                        fcnt_d = fcnt_q;
                    end
                end
                ST_WDOG: begin
                    state_d = ST_WDOG;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        flush_d = {STAGES{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            flush_d[i] = (state_d == ST_FLUSH) && (int'(r_d) > i);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= {RW{1'b0}};
            fcnt_q  <= 4'd0;
            wcnt_q  <= {WDOG_W{1'b0}};
            flush_q <= {STAGES{1'b0}};
            trip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            flush_q <= flush_d;
            trip_q  <= trip_d;
        end
    end

    assign stall     = stall_s;
    assign bubble    = bubble_s;
    assign flush     = flush_q;
    assign wdog_trip = trip_q;

`ifdef PIPE_HAZARD_PERF_EN
    localparam logic [PERF_W-1:0] PONE = {{(PERF_W-1){1'b0}}, 1'b1};
    logic [PERF_W-1:0] pstall_q, pflush_q;

    // Saturating performance counters, advancing only while the pipeline is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstall_q <= {PERF_W{1'b0}};
            pflush_q <= {PERF_W{1'b0}};
        end else begin
            if (rdy && (|stall_s) && !(&pstall_q)) begin
                pstall_q <= pstall_q + PONE;
            end
            if (accept_s && !(&pflush_q)) begin
                pflush_q <= pflush_q + PONE;
            end
        end
    end

    assign perf_stall_cnt = pstall_q;
    assign perf_flush_cnt = pflush_q;
`else
    assign perf_stall_cnt = {PERF_W{1'b0}};
    assign perf_flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: constant vector table, hand corner sequences and
// randomized traffic against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;
    localparam int S  = 5;
    localparam int FL = 2;
    localparam int WW = 3;
    localparam int PW = 32;

    logic          clk, rst, rdy, redirect;
    logic [S-1:0]  stall_req;
    logic [2:0]    redirect_stage;
    logic [S-1:0]  stall, bubble, flush;
    logic          wdog_trip;
    logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          m_trip;
    int          m_fleft, m_r, m_wcnt;
    int unsigned m_pstall, m_pflush;
    logic [S-1:0] e_stall, e_bubble, e_flush;

    typedef struct {
        logic [4:0] req;
        logic       redir;
        logic [2:0] rs;
        logic       rd;
        logic [4:0] x_stall;
        logic [4:0] x_bubble;
        logic [4:0] x_flush;
        logic       x_trip;
    } vec_t;

    vec_t vecs[18];

    pipe_hazard_ctrl #(.STAGES(S), .FLUSH_LEN(FL), .WDOG_W(WW), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req),
        .redirect(redirect), .redirect_stage(redirect_stage),
        .stall(stall), .bubble(bubble), .flush(flush), .wdog_trip(wdog_trip),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_trip = 1'b0; m_fleft = 0; m_r = 0; m_wcnt = 0; m_pstall = 0; m_pflush = 0;
    endtask

    // Drive one cycle of inputs, then compare all outputs with the model at the falling edge.
    task automatic drive_and_check(input logic [4:0] req, input logic redir,
                                   input logic [2:0] rs, input logic rd);
        int k;
        stall_req = req; redirect = redir; redirect_stage = rs; rdy = rd;
        @(negedge clk);
        k = -1;
        for (int i = 0; i < S; i++) if (req[i]) k = i;
        e_flush = '0;
        if (m_fleft > 0 && !m_trip)
            for (int i = 0; i < S; i++) e_flush[i] = (i < m_r);
        e_stall = '0;
        if (!rd || m_trip) e_stall = '1;
        else for (int i = 0; i < S; i++) e_stall[i] = (i <= k) && !e_flush[i];
        e_bubble = '0;
        for (int i = 1; i < S; i++) e_bubble[i] = e_stall[i-1] && !e_stall[i] && !e_flush[i];
        chk("model_stall", 32'(stall), 32'(e_stall));
        chk("model_bubble", 32'(bubble), 32'(e_bubble));
        chk("model_flush", 32'(flush), 32'(e_flush));
        chk("model_trip", 32'(wdog_trip), 32'(m_trip));
`ifdef PIPE_HAZARD_PERF_EN
        chk("model_perf_stall", perf_stall_cnt, m_pstall);
        chk("model_perf_flush", perf_flush_cnt, m_pflush);
`else
        chk("model_perf_stall", perf_stall_cnt, 32'd0);
        chk("model_perf_flush", perf_flush_cnt, 32'd0);
`endif
    endtask

    // Apply the clock edge to the model, then step the DUT to just after the edge.
    task automatic advance();
        if (|stall_req) m_wcnt = (m_wcnt < (1 << WW) - 1) ? m_wcnt + 1 : m_wcnt;
        else m_wcnt = 0;
        if (rdy && (|e_stall)) m_pstall++;
        if (m_wcnt == (1 << WW) - 1) begin
            m_trip = 1'b1;
            m_fleft = 0;
        end else if (!m_trip && rdy) begin
            if (redirect && redirect_stage != 3'd0) begin
                m_r = (m_fleft > 0 && m_r > int'(redirect_stage)) ? m_r : int'(redirect_stage);
                m_fleft = FL;
                m_pflush++;
            end else if (m_fleft > 0) begin
                m_fleft--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [4:0] req, input logic redir,
                        input logic [2:0] rs, input logic rd);
        drive_and_check(req, redir, rs, rd);
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1; stall_req = '0; redirect = 1'b0; redirect_stage = '0; rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h1f);
        chk("rst_bubble", 32'(bubble), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_trip", 32'(wdog_trip), 32'h0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_perf_flush", perf_flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        //            req       rd  rs    rdy   stall     bubble    flush     trip
        vecs[0]  = '{5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[1]  = '{5'b00010, 1'b0, 3'd0, 1'b1, 5'b00011, 5'b00100, 5'b00000, 1'b0};
        vecs[2]  = '{5'b10010, 1'b0, 3'd0, 1'b1, 5'b11111, 5'b00000, 5'b00000, 1'b0};
        vecs[3]  = '{5'b00000, 1'b1, 3'd3, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[4]  = '{5'b00000, 1'b1, 3'd2, 1'b1, 5'b00000, 5'b00000, 5'b00111, 1'b0};
        vecs[5]  = '{5'b01000, 1'b0, 3'd0, 1'b1, 5'b01000, 5'b10000, 5'b00111, 1'b0};
        vecs[6]  = '{5'b00001, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00111, 1'b0};
        vecs[7]  = '{5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[8]  = '{5'b00000, 1'b1, 3'd4, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[9]  = '{5'b00000, 1'b0, 3'd0, 1'b0, 5'b11111, 5'b00000, 5'b01111, 1'b0};
        vecs[10] = '{5'b00000, 1'b0, 3'd0, 1'b0, 5'b11111, 5'b00000, 5'b01111, 1'b0};
        vecs[11] = '{5'b10000, 1'b0, 3'd0, 1'b1, 5'b10000, 5'b00000, 5'b01111, 1'b0};
        vecs[12] = '{5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b01111, 1'b0};
        vecs[13] = '{5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[14] = '{5'b00000, 1'b1, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[15] = '{5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[16] = '{5'b00100, 1'b0, 3'd0, 1'b1, 5'b00111, 5'b01000, 5'b00000, 1'b0};
        vecs[17] = '{5'b00001, 1'b0, 3'd0, 1'b1, 5'b00001, 5'b00010, 5'b00000, 1'b0};

        do_reset();

        for (int v = 0; v < 18; v++) begin
            drive_and_check(vecs[v].req, vecs[v].redir, vecs[v].rs, vecs[v].rd);
            chk($sformatf("tab%0d_stall", v), 32'(stall), 32'(vecs[v].x_stall));
            chk($sformatf("tab%0d_bubble", v), 32'(bubble), 32'(vecs[v].x_bubble));
            chk($sformatf("tab%0d_flush", v), 32'(flush), 32'(vecs[v].x_flush));
            chk($sformatf("tab%0d_trip", v), 32'(wdog_trip), 32'(vecs[v].x_trip));
            advance();
        end

        // Watchdog: seven consecutive stalled cycles trip it; only reset clears it.
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            drive_and_check(5'b00001, 1'b0, 3'd0, 1'b1);
            chk($sformatf("wdog_pre%0d", c), 32'(wdog_trip), 32'h0);
            advance();
        end
        for (int c = 0; c < 3; c++) begin
            drive_and_check(5'b00000, 1'b1, 3'd3, 1'b1);
            chk("wdog_trip_sticky", 32'(wdog_trip), 32'h1);
            chk("wdog_stall_ones", 32'(stall), 32'h1f);
            chk("wdog_no_flush", 32'(flush), 32'h0);
            advance();
        end
        do_reset();
        drive_and_check(5'b00000, 1'b0, 3'd0, 1'b1);
        chk("wdog_cleared", 32'(wdog_trip), 32'h0);
        advance();

        // Performance counters: four stalled cycles plus one accepted redirect.
        do_reset();
        for (int c = 0; c < 4; c++) step(5'b00001, 1'b0, 3'd0, 1'b1);
        step(5'b00000, 1'b1, 3'd1, 1'b1);
        drive_and_check(5'b00000, 1'b0, 3'd0, 1'b1);
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_stall_4", perf_stall_cnt, 32'd4);
        chk("perf_flush_1", perf_flush_cnt, 32'd1);
`else
        chk("perf_stall_off", perf_stall_cnt, 32'd0);
        chk("perf_flush_off", perf_flush_cnt, 32'd0);
`endif
        advance();

        // Reset mid-flush aborts the flush without waiting for a clock edge.
        do_reset();
        step(5'b00000, 1'b1, 3'd3, 1'b1);
        drive_and_check(5'b00000, 1'b0, 3'd0, 1'b1);
        chk("midflush_active", 32'(flush), 32'h07);
        #2;
        rst = 1'b1;
        #1;
        chk("midflush_rst_flush", 32'(flush), 32'h0);
        chk("midflush_rst_stall", 32'(stall), 32'h1f);
        chk("midflush_rst_bubble", 32'(bubble), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized traffic with increasing stall density per episode.
        for (int e = 0; e < 6; e++) begin
            int pct;
            pct = 20 + e * 12;
            do_reset();
            for (int c = 0; c < 80; c++) begin
                logic [4:0] rq;
                logic       rr, ry;
                logic [2:0] rsg;
                rq  = ($urandom_range(0, 99) < pct) ? 5'($urandom_range(1, 31)) : 5'b00000;
                rr  = ($urandom_range(0, 3) == 0);
                rsg = 3'($urandom_range(0, 7));
                ry  = ($urandom_range(0, 9) < 8);
                step(rq, rr, rsg, ry);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline stall/flush controller for the RV32I core. It replaces the fixed five-bit stall bus with an N-stage version that adds three things: bubble-insertion outputs, a multi-cycle flush sequencer driven by branch redirects, and a stall watchdog that flags a stall held too long. It sits beside the pipeline registers. Every stage register takes its `stall`, `bubble` and `flush` bit from this block.

## Interface
Parameters:
- `STAGES`, 5: number of pipeline slots. Bit 0 is the PC/fetch slot; bit `STAGES-1` is the last stage.
- `FLUSH_LEN`, 1: cycles that flush is held after a redirect. Range 1..15.
- `WDOG_W`, 10: watchdog counter width. Timeout is 2^WDOG_W-1 consecutive stalled cycles.
- `PERF_W`, 32: performance counter width (only with the perf macro).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `rdy` in 1: global ready. Low freezes the whole pipeline.
- `stall_req` in STAGES: per-stage stall request.
- `redirect` in 1: branch/jump redirect pulse from EX.
- `redirect_stage` in $clog2(STAGES): index of the redirecting stage.
- `stall` out STAGES: hold the stage register.
- `bubble` out STAGES: load a NOP into the stage register.
- `flush` out STAGES: invalidate the stage register.
- `wdog_trip` out 1: sticky watchdog flag.
- `perf_stall_cnt` out PERF_W: total cycles with any stall asserted (perf builds only).
- `perf_flush_cnt` out PERF_W: total redirects accepted (perf builds only).

## Operation
- **Stall vector (combinational):**
  - Let `k` be the highest index with `stall_req[k]=1`. Then `stall[i]=1` for all `i<=k`.
  - If `rst`, or `rdy=0`, or the FSM is in WDOG, then `stall` is all ones.
  - Example: `STAGES=5`, a request on stage 1 gives `5'b00011`; a request on stage 4 gives `5'b11111`.
- **Bubble:** `bubble[i+1] = stall[i] & ~stall[i+1] & ~flush[i+1]`. `bubble[0]` is always 0.
- **Flush FSM.** States are IDLE, FLUSH and WDOG.
  - IDLE → FLUSH when `redirect` is high and `rdy` is high. On that edge the block latches `r = redirect_stage` and loads `fcnt = FLUSH_LEN-1`.
  - In FLUSH, `flush[i]=1` for all `i<r`, registered (see Timing).
  - FLUSH decrements `fcnt` each cycle that `rdy` is high. It returns to IDLE when `fcnt=0`.
  - A new `redirect` arriving while in FLUSH restarts the sequence: it re-latches `r`, keeping the larger of the old and new index, and reloads `fcnt`.
  - Stall wins over flush for a stage only when `stall_req` comes from a stage at or beyond `r`. For stages `i<r`, flush overrides stall and the `stall` output is forced to 0 for those bits.
  - `redirect` with `redirect_stage=0` is ignored (nothing older than fetch).
- **Watchdog:**
  - `wcnt` increments on each cycle where `|stall_req` is high. Any cycle with `stall_req=0` clears it.
  - It saturates at all-ones. At saturation the FSM enters WDOG and sets `wdog_trip`.
  - WDOG is left only by reset. `wdog_trip` stays high until reset.
- **Width rule:** all counters saturate. None wraps.

## Timing
- `stall` and `bubble` respond combinationally to `stall_req` in the same cycle (zero latency).
- `flush` is registered. It is asserted starting in the cycle after the `redirect` edge and lasts exactly `FLUSH_LEN` cycles with `rdy` high. While `rdy` is low, `flush` holds its value.
- Reset values: `stall` is all ones; `bubble`, `flush` and `wdog_trip` are 0; the FSM is in IDLE; `wcnt` and `fcnt` are 0; the perf counters are 0.
- Reset asserted mid-flush aborts the flush immediately and asynchronously. `flush` goes to 0 and `stall` goes to all ones.
- If `redirect` and `stall_req` are both high in the same cycle, the redirect is still accepted. The stall vector for that cycle is computed as if in IDLE.

## Configuration
- `PIPE_HAZARD_PERF_EN` defined:
  - `perf_stall_cnt` and `perf_flush_cnt` are present and saturating.
  - They increment only while `rdy` is high.
- Not defined:
  - Both ports are tied to 0.
  - No counter flops are inferred.

## Test plan
- Reset, then release with `stall_req=0` and `rdy=1`: `stall` goes from `5'b11111` to `5'b00000`; `flush` and `wdog_trip` stay 0.
- `stall_req=5'b00010` → `stall=5'b00011` and `bubble=5'b00100` in the same cycle. Then `stall_req=5'b10010` → `stall=5'b11111`, `bubble=0`.
- `redirect=1` with `redirect_stage=3`, `FLUSH_LEN=2` → `flush=5'b00111` for exactly the next 2 cycles, then 0. A second redirect with `redirect_stage=2` at flush cycle 1 extends the flush to 2 more cycles with `r=3`.
- `rdy=0` during a flush → `stall=5'b11111`, `flush` holds, and the count resumes when `rdy` returns to 1.
- `WDOG_W=3`, `stall_req=5'b00001` held → `wdog_trip` rises after 7 cycles and `stall` becomes all ones. Only `rst` clears it.
- With `PIPE_HAZARD_PERF_EN`, 4 stalled cycles plus 1 redirect → `perf_stall_cnt=4` and `perf_flush_cnt=1`. Without the macro, both read 0.
